// File: rtl/ctrl_sequencer_if.sv
// Control bus between the sequencer and the datapath registers it steers:
// the opcode coming back from the IR, the T-state ring and every load/enable pin.
interface ctrl_sequencer_if #(
  parameter int OPC_W = 4
);
  logic [OPC_W-1:0] opcode;
  logic [5:0]       tstate;
  logic             pc_inc;
  logic             pc_en;
  logic             pc_load;
  logic             mar_load;
  logic             ram_en;
  logic             ir_load;
  logic             ir_en;
  logic             a_load;
  logic             a_en;
  logic             b_load;
  logic             alu_en;
  logic             alu_sub;
  logic             out_load;
  logic             halt;

  // Sequencer side: consumes the opcode, drives the control word.
  modport master (
    input  opcode,
    output tstate, pc_inc, pc_en, pc_load, mar_load, ram_en, ir_load, ir_en,
           a_load, a_en, b_load, alu_en, alu_sub, out_load, halt
  );

  // Datapath side: supplies the opcode, obeys the control word.
  modport slave (
    output opcode,
    input  tstate, pc_inc, pc_en, pc_load, mar_load, ram_en, ir_load, ir_en,
           a_load, a_en, b_load, alu_en, alu_sub, out_load, halt
  );
endinterface

// File: rtl/ctrl_sequencer.sv
// Microcode control sequencer: one-hot T-state ring plus a halted flag.
// The control word is a pure decode of (tstate, opcode, halted) so it only
// changes on clock edges (or on reset assertion, which forces it to zero).
module ctrl_sequencer #(
  parameter int OPC_W     = 4,
  parameter bit EARLY_END = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  ctrl_sequencer_if.master bus
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  typedef struct packed {
    logic pc_inc;
    logic pc_en;
    logic pc_load;
    logic mar_load;
    logic ram_en;
    logic ir_load;
    logic ir_en;
    logic a_load;
    logic a_en;
    logic b_load;
    logic alu_en;
    logic alu_sub;
    logic out_load;
    logic halt;
  } ctrl_t;

  localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(4'b0000);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(4'b0001);
  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(4'b0010);
  localparam logic [OPC_W-1:0] OP_LDI = OPC_W'(4'b0101);
  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(4'b0110);
  localparam logic [OPC_W-1:0] OP_OUT = OPC_W'(4'b1110);
  localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(4'b1111);

  tstate_e tstate_q, tstate_d;
  logic    halted_q, halted_d;
  ctrl_t   cw;
  ctrl_t   cw_out;
  logic    last_step;

  // Decode the control word for the current step and pick the next T-state.
  always_comb begin
    cw        = '0;
    last_step = 1'b0;
    halted_d  = halted_q;
    tstate_d  = tstate_e'({tstate_q[4:0], tstate_q[5]});

    if (halted_q) begin
      // Frozen: only the halt line is shown, the opcode is ignored.
      cw.halt  = 1'b1;
      tstate_d = tstate_q;
    end else begin
      case (tstate_q)
        T1: begin cw.pc_en = 1'b1; cw.mar_load = 1'b1; end
        T2: begin cw.pc_inc = 1'b1; end
        T3: begin cw.ram_en = 1'b1; cw.ir_load = 1'b1; end
        T4: begin
          case (bus.opcode)
            OP_LDA, OP_ADD, OP_SUB: begin cw.ir_en = 1'b1; cw.mar_load = 1'b1; end
            OP_LDI: begin cw.ir_en = 1'b1; cw.a_load   = 1'b1; last_step = 1'b1; end
            OP_JMP: begin cw.ir_en = 1'b1; cw.pc_load  = 1'b1; last_step = 1'b1; end
            OP_OUT: begin cw.a_en  = 1'b1; cw.out_load = 1'b1; last_step = 1'b1; end
            OP_HLT: begin cw.halt  = 1'b1; halted_d = 1'b1; end
            default: last_step = 1'b1;
          endcase
        end
        T5: begin
          case (bus.opcode)
            OP_LDA: begin cw.ram_en = 1'b1; cw.a_load = 1'b1; last_step = 1'b1; end
            OP_ADD, OP_SUB: begin cw.ram_en = 1'b1; cw.b_load = 1'b1; end
            default: ;
          endcase
        end
        T6: begin
          if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            cw.alu_en  = 1'b1;
            cw.a_load  = 1'b1;
            cw.alu_sub = (bus.opcode == OP_SUB);
          end
        end
        default: ;
      endcase

      // Halting pins the ring at T4; otherwise short instructions may skip ahead.
      if (halted_d) begin
        tstate_d = tstate_q;
      end else if (EARLY_END && last_step) begin
        tstate_d = T1;
      end
    end
  end

  // Register the ring position and the halted flag; reset starts a fresh fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      tstate_q <= T1;
      halted_q <= 1'b0;
    end else begin
      tstate_q <= tstate_d;
      halted_q <= halted_d;
    end
  end

  // All control lines are held low for as long as reset is asserted.
  always_comb begin
    cw_out = rst ? '0 : cw;
  end

  assign bus.tstate   = tstate_q;
  assign bus.pc_inc   = cw_out.pc_inc;
  assign bus.pc_en    = cw_out.pc_en;
  assign bus.pc_load  = cw_out.pc_load;
  assign bus.mar_load = cw_out.mar_load;
  assign bus.ram_en   = cw_out.ram_en;
  assign bus.ir_load  = cw_out.ir_load;
  assign bus.ir_en    = cw_out.ir_en;
  assign bus.a_load   = cw_out.a_load;
  assign bus.a_en     = cw_out.a_en;
  assign bus.b_load   = cw_out.b_load;
  assign bus.alu_en   = cw_out.alu_en;
  assign bus.alu_sub  = cw_out.alu_sub;
  assign bus.out_load = cw_out.out_load;
  assign bus.halt     = cw_out.halt;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: one instance with early end, one without.
module tb_ctrl_sequencer;

  localparam logic [13:0] C_PC_INC  = 14'h2000;
  localparam logic [13:0] C_PC_EN   = 14'h1000;
  localparam logic [13:0] C_PC_LOAD = 14'h0800;
  localparam logic [13:0] C_MAR     = 14'h0400;
  localparam logic [13:0] C_RAM_EN  = 14'h0200;
  localparam logic [13:0] C_IR_LOAD = 14'h0100;
  localparam logic [13:0] C_IR_EN   = 14'h0080;
  localparam logic [13:0] C_A_LOAD  = 14'h0040;
  localparam logic [13:0] C_A_EN    = 14'h0020;
  localparam logic [13:0] C_B_LOAD  = 14'h0010;
  localparam logic [13:0] C_ALU_EN  = 14'h0008;
  localparam logic [13:0] C_ALU_SUB = 14'h0004;
  localparam logic [13:0] C_OUT     = 14'h0002;
  localparam logic [13:0] C_HALT    = 14'h0001;

  logic clk;
  logic rst;
  int   ncmp;
  int   nfail;

  ctrl_sequencer_if #(.OPC_W(4)) a_if ();
  ctrl_sequencer_if #(.OPC_W(4)) b_if ();

  ctrl_sequencer #(.OPC_W(4), .EARLY_END(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
  ctrl_sequencer #(.OPC_W(4), .EARLY_END(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(b_if));

  always #5 clk = ~clk;

  // Packs the observed control word in the same bit order as the C_* masks.
  function automatic logic [13:0] cw_a();
    return {a_if.pc_inc, a_if.pc_en, a_if.pc_load, a_if.mar_load, a_if.ram_en,
            a_if.ir_load, a_if.ir_en, a_if.a_load, a_if.a_en, a_if.b_load,
            a_if.alu_en, a_if.alu_sub, a_if.out_load, a_if.halt};
  endfunction

  function automatic logic [13:0] cw_b();
    return {b_if.pc_inc, b_if.pc_en, b_if.pc_load, b_if.mar_load, b_if.ram_en,
            b_if.ir_load, b_if.ir_en, b_if.a_load, b_if.a_en, b_if.b_load,
            b_if.alu_en, b_if.alu_sub, b_if.out_load, b_if.halt};
  endfunction

  function automatic int bus_a();
    return $countones({a_if.pc_en, a_if.ram_en, a_if.ir_en, a_if.a_en, a_if.alu_en});
  endfunction

  function automatic int bus_b();
    return $countones({b_if.pc_en, b_if.ram_en, b_if.ir_en, b_if.a_en, b_if.alu_en});
  endfunction

  task automatic set_opc(input logic [3:0] v);
    a_if.opcode = v;
    b_if.opcode = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_opc(4'bxxxx);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      ncmp++;
      if (cw_a() !== 14'h0) begin
        nfail++; $display("FAIL reset_ctrl[%0d]: got %h want %h", i, cw_a(), 14'h0);
      end
      ncmp++;
      if (cw_b() !== 14'h0) begin
        nfail++; $display("FAIL reset_ctrl_b[%0d]: got %h want %h", i, cw_b(), 14'h0);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    ncmp++;
    if (a_if.tstate !== 6'b000001) begin
      nfail++; $display("FAIL reset_tstate: got %b want %b", a_if.tstate, 6'b000001);
    end
    ncmp++;
    if (cw_a() !== (C_PC_EN | C_MAR)) begin
      nfail++; $display("FAIL reset_first_fetch: got %h want %h", cw_a(), C_PC_EN | C_MAR);
    end
    $display("reset: released, first T1 fetch observed");
  endtask

  task automatic test_lda();
    logic [13:0] exp_cw [5];
    logic [5:0]  want_t;
    exp_cw = '{C_PC_EN | C_MAR, C_PC_INC, C_RAM_EN | C_IR_LOAD,
               C_IR_EN | C_MAR, C_RAM_EN | C_A_LOAD};
    set_opc(4'b0000);
    #1;
    for (int i = 0; i < 5; i++) begin
      want_t = 6'b000001 << i;
      ncmp++;
      if (a_if.tstate !== want_t) begin
        nfail++; $display("FAIL lda_tstate[%0d]: got %b want %b", i, a_if.tstate, want_t);
      end
      ncmp++;
      if (cw_a() !== exp_cw[i]) begin
        nfail++; $display("FAIL lda_ctrl[%0d]: got %h want %h", i, cw_a(), exp_cw[i]);
      end
      ncmp++;
      if (bus_a() > 1) begin
        nfail++; $display("FAIL lda_bus_onehot[%0d]: got %0d drivers want <=1", i, bus_a());
      end
      @(negedge clk); #1;
    end
    ncmp++;
    if (a_if.tstate !== 6'b000001) begin
      nfail++; $display("FAIL lda_wrap: got %b want %b", a_if.tstate, 6'b000001);
    end
    $display("lda: 5-cycle instruction done");
  endtask

  task automatic test_add_sub();
    logic [13:0] exp_cw [6];
    logic [3:0]  opcs [2];
    logic [5:0]  want_t;
    opcs = '{4'b0001, 4'b0010};
    for (int k = 0; k < 2; k++) begin
      exp_cw = '{C_PC_EN | C_MAR, C_PC_INC, C_RAM_EN | C_IR_LOAD,
                 C_IR_EN | C_MAR, C_RAM_EN | C_B_LOAD,
                 (k == 1) ? (C_ALU_EN | C_A_LOAD | C_ALU_SUB) : (C_ALU_EN | C_A_LOAD)};
      set_opc(opcs[k]);
      #1;
      for (int i = 0; i < 6; i++) begin
        want_t = 6'b000001 << i;
        ncmp++;
        if (a_if.tstate !== want_t) begin
          nfail++; $display("FAIL addsub_tstate[%0d][%0d]: got %b want %b", k, i, a_if.tstate, want_t);
        end
        ncmp++;
        if (cw_a() !== exp_cw[i]) begin
          nfail++; $display("FAIL addsub_ctrl[%0d][%0d]: got %h want %h", k, i, cw_a(), exp_cw[i]);
        end
        ncmp++;
        if (bus_a() > 1) begin
          nfail++; $display("FAIL addsub_bus_onehot[%0d][%0d]: got %0d drivers want <=1", k, i, bus_a());
        end
        @(negedge clk); #1;
      end
      ncmp++;
      if (a_if.tstate !== 6'b000001) begin
        nfail++; $display("FAIL addsub_wrap[%0d]: got %b want %b", k, a_if.tstate, 6'b000001);
      end
      $display("addsub: opcode %b 6-cycle instruction done", opcs[k]);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  opcs [3];
    logic [13:0] t4_cw [3];
    logic [13:0] exp_cw [4];
    logic [5:0]  want_t;
    opcs  = '{4'b1110, 4'b0110, 4'b0111};
    t4_cw = '{C_A_EN | C_OUT, C_IR_EN | C_PC_LOAD, 14'h0000};
    for (int k = 0; k < 3; k++) begin
      exp_cw = '{C_PC_EN | C_MAR, C_PC_INC, C_RAM_EN | C_IR_LOAD, t4_cw[k]};
      set_opc(opcs[k]);
      #1;
      for (int i = 0; i < 4; i++) begin
        want_t = 6'b000001 << i;
        ncmp++;
        if (a_if.tstate !== want_t) begin
          nfail++; $display("FAIL b2b_tstate[%0d][%0d]: got %b want %b", k, i, a_if.tstate, want_t);
        end
        ncmp++;
        if (cw_a() !== exp_cw[i]) begin
          nfail++; $display("FAIL b2b_ctrl[%0d][%0d]: got %h want %h", k, i, cw_a(), exp_cw[i]);
        end
        ncmp++;
        if (bus_a() > 1) begin
          nfail++; $display("FAIL b2b_bus_onehot[%0d][%0d]: got %0d drivers want <=1", k, i, bus_a());
        end
        @(negedge clk); #1;
      end
      ncmp++;
      if (a_if.tstate !== 6'b000001) begin
        nfail++; $display("FAIL b2b_wrap[%0d]: got %b want %b", k, a_if.tstate, 6'b000001);
      end
      $display("b2b: opcode %b 4-cycle instruction done", opcs[k]);
    end
  endtask

  task automatic test_halt();
    logic [13:0] exp_cw [4];
    logic [5:0]  want_t;
    exp_cw = '{C_PC_EN | C_MAR, C_PC_INC, C_RAM_EN | C_IR_LOAD, C_HALT};
    set_opc(4'b1111);
    #1;
    for (int i = 0; i < 4; i++) begin
      want_t = 6'b000001 << i;
      ncmp++;
      if (a_if.tstate !== want_t) begin
        nfail++; $display("FAIL hlt_tstate[%0d]: got %b want %b", i, a_if.tstate, want_t);
      end
      ncmp++;
      if (cw_a() !== exp_cw[i]) begin
        nfail++; $display("FAIL hlt_ctrl[%0d]: got %h want %h", i, cw_a(), exp_cw[i]);
      end
      if (i < 3) begin
        @(negedge clk); #1;
      end
    end
    // Held halted for 10 cycles while the opcode wanders.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      set_opc(4'(i));
      #1;
      ncmp++;
      if (a_if.tstate !== 6'b001000) begin
        nfail++; $display("FAIL halted_tstate[%0d]: got %b want %b", i, a_if.tstate, 6'b001000);
      end
      ncmp++;
      if (cw_a() !== C_HALT) begin
        nfail++; $display("FAIL halted_ctrl[%0d]: got %h want %h", i, cw_a(), C_HALT);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    ncmp++;
    if (a_if.tstate !== 6'b000001) begin
      nfail++; $display("FAIL hlt_resume_tstate: got %b want %b", a_if.tstate, 6'b000001);
    end
    ncmp++;
    if (cw_a() !== (C_PC_EN | C_MAR)) begin
      nfail++; $display("FAIL hlt_resume_ctrl: got %h want %h", cw_a(), C_PC_EN | C_MAR);
    end
    $display("halt: held 10 cycles, resumed after reset");
  endtask

  task automatic test_reset_mid();
    logic [13:0] exp_cw [4];
    exp_cw = '{C_PC_EN | C_MAR, C_PC_INC, C_RAM_EN | C_IR_LOAD, C_IR_EN | C_MAR};
    set_opc(4'b0001);
    #1;
    for (int i = 0; i < 4; i++) begin
      ncmp++;
      if (cw_a() !== exp_cw[i]) begin
        nfail++; $display("FAIL midrst_ctrl[%0d]: got %h want %h", i, cw_a(), exp_cw[i]);
      end
      @(negedge clk); #1;
    end
    // Now in T5 of ADD; reset must suppress b_load immediately.
    rst = 1'b1;
    #1;
    ncmp++;
    if (a_if.b_load !== 1'b0) begin
      nfail++; $display("FAIL midrst_b_load: got %b want %b", a_if.b_load, 1'b0);
    end
    ncmp++;
    if (cw_a() !== 14'h0) begin
      nfail++; $display("FAIL midrst_zero: got %h want %h", cw_a(), 14'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    ncmp++;
    if (a_if.tstate !== 6'b000001) begin
      nfail++; $display("FAIL midrst_tstate: got %b want %b", a_if.tstate, 6'b000001);
    end
    ncmp++;
    if (cw_a() !== (C_PC_EN | C_MAR)) begin
      nfail++; $display("FAIL midrst_fetch: got %h want %h", cw_a(), C_PC_EN | C_MAR);
    end
    $display("midrst: ADD aborted at T5, fresh fetch");
  endtask

  task automatic test_full_length();
    logic [13:0] exp_cw [6];
    logic [5:0]  want_t;
    exp_cw = '{C_PC_EN | C_MAR, C_PC_INC, C_RAM_EN | C_IR_LOAD,
               C_IR_EN | C_A_LOAD, 14'h0000, 14'h0000};
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_opc(4'b0101);
    #1;
    for (int i = 0; i < 6; i++) begin
      want_t = 6'b000001 << i;
      ncmp++;
      if (b_if.tstate !== want_t) begin
        nfail++; $display("FAIL ldi6_tstate[%0d]: got %b want %b", i, b_if.tstate, want_t);
      end
      ncmp++;
      if (cw_b() !== exp_cw[i]) begin
        nfail++; $display("FAIL ldi6_ctrl[%0d]: got %h want %h", i, cw_b(), exp_cw[i]);
      end
      ncmp++;
      if (bus_b() > 1) begin
        nfail++; $display("FAIL ldi6_bus_onehot[%0d]: got %0d drivers want <=1", i, bus_b());
      end
      @(negedge clk); #1;
    end
    ncmp++;
    if (b_if.tstate !== 6'b000001) begin
      nfail++; $display("FAIL ldi6_wrap: got %b want %b", b_if.tstate, 6'b000001);
    end
    $display("ldi6: LDI ran full 6 cycles without early end");
  endtask

  initial begin
    clk   = 1'b0;
    rst   = 1'b1;
    ncmp  = 0;
    nfail = 0;
    set_opc(4'b0000);
    test_reset();
    test_lda();
    test_add_sub();
    test_back_to_back();
    test_halt();
    test_reset_mid();
    test_full_length();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
